// File: rtl/reg_scoreboard.sv
// Decode-side dependency scoreboard: per-register pending-write counters for RF, VRF and CC.
// Counters rise on issue and fall on writeback; any hazard on a used source or saturated dest stalls Decode.
module reg_scoreboard #(
  parameter int NUM_RF    = 16,
  parameter int NUM_VRF   = 64,
  parameter int VREG_ID_W = 6,
  parameter int CNT_W     = 2
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESETn,
  input  logic                 I_LOCK,
  input  logic                 I_Issue,
  input  logic [3:0]           I_Src1Idx,
  input  logic                 I_Src1Use,
  input  logic [3:0]           I_Src2Idx,
  input  logic                 I_Src2Use,
  input  logic [VREG_ID_W-1:0] I_VSrc1Idx,
  input  logic                 I_VSrc1Use,
  input  logic [VREG_ID_W-1:0] I_VSrc2Idx,
  input  logic                 I_VSrc2Use,
  input  logic                 I_CCUse,
  input  logic [3:0]           I_DestIdx,
  input  logic                 I_DestWrite,
  input  logic [VREG_ID_W-1:0] I_VDestIdx,
  input  logic                 I_VDestWrite,
  input  logic                 I_CCWrite,
  input  logic                 I_RetireRegWEn,
  input  logic [3:0]           I_RetireRegIdx,
  input  logic                 I_RetireVRegWEn,
  input  logic [VREG_ID_W-1:0] I_RetireVRegIdx,
  input  logic                 I_RetireCCWEn,
  input  logic                 I_Flush,
  output logic                 O_DepStallSignal,
  output logic                 O_Issued,
  output logic                 O_Busy,
  output logic [15:0]          O_StallCycles,
  output logic                 O_Error
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [CNT_W-1:0] rf_cnt  [NUM_RF];
  logic [CNT_W-1:0] rf_nxt  [NUM_RF];
  logic [CNT_W-1:0] vrf_cnt [NUM_VRF];
  logic [CNT_W-1:0] vrf_nxt [NUM_VRF];
  logic [CNT_W-1:0] cc_cnt;
  logic [CNT_W-1:0] cc_nxt;
  logic             busy_nxt;
  logic             err_set;
  logic             src_hit;
  logic             dest_sat;

  function automatic logic v_ok(input logic [VREG_ID_W-1:0] idx);
    return int'(idx) < NUM_VRF;
  endfunction

  // Issue handshake: I_Issue is valid, !O_DepStallSignal is ready; an instruction
  // is accepted (O_Issued) only on a cycle where both hold and I_LOCK=1.
  always_comb begin
    src_hit  = (I_Src1Use && rf_cnt[I_Src1Idx] != '0)
            || (I_Src2Use && rf_cnt[I_Src2Idx] != '0)
            || (I_VSrc1Use && v_ok(I_VSrc1Idx) && vrf_cnt[I_VSrc1Idx] != '0)
            || (I_VSrc2Use && v_ok(I_VSrc2Idx) && vrf_cnt[I_VSrc2Idx] != '0)
            || (I_CCUse && cc_cnt != '0);
    dest_sat = (I_DestWrite && rf_cnt[I_DestIdx] == CNT_SAT)
            || (I_VDestWrite && v_ok(I_VDestIdx) && vrf_cnt[I_VDestIdx] == CNT_SAT)
            || (I_CCWrite && cc_cnt == CNT_SAT);
  end

  assign O_DepStallSignal = I_Issue && (src_hit || dest_sat);
  assign O_Issued         = I_Issue && !O_DepStallSignal && I_LOCK;

  // Decrements are gated on cnt>0 so an underflowing retire leaves the counter at zero.
  always_comb begin
    busy_nxt = 1'b0;
    for (int i = 0; i < NUM_RF; i++) begin
      rf_nxt[i] = rf_cnt[i];
      if (I_LOCK) begin
        if (I_Flush) rf_nxt[i] = '0;
        else rf_nxt[i] = rf_cnt[i]
          + CNT_W'(O_Issued && I_DestWrite && I_DestIdx == 4'(i))
          - CNT_W'(I_RetireRegWEn && I_RetireRegIdx == 4'(i) && rf_cnt[i] != '0);
      end
      busy_nxt = busy_nxt | (rf_nxt[i] != '0);
    end
    for (int j = 0; j < NUM_VRF; j++) begin
      vrf_nxt[j] = vrf_cnt[j];
      if (I_LOCK) begin
        if (I_Flush) vrf_nxt[j] = '0;
        else vrf_nxt[j] = vrf_cnt[j]
          + CNT_W'(O_Issued && I_VDestWrite && I_VDestIdx == VREG_ID_W'(j))
          - CNT_W'(I_RetireVRegWEn && I_RetireVRegIdx == VREG_ID_W'(j) && vrf_cnt[j] != '0);
      end
      busy_nxt = busy_nxt | (vrf_nxt[j] != '0);
    end
    cc_nxt = cc_cnt;
    if (I_LOCK) begin
      if (I_Flush) cc_nxt = '0;
      else cc_nxt = cc_cnt + CNT_W'(O_Issued && I_CCWrite)
                           - CNT_W'(I_RetireCCWEn && cc_cnt != '0);
    end
    busy_nxt = busy_nxt | (cc_nxt != '0);
  end

  always_comb begin
    err_set = I_LOCK && !I_Flush && (
                (I_RetireRegWEn && rf_cnt[I_RetireRegIdx] == '0)
             || (I_RetireVRegWEn && v_ok(I_RetireVRegIdx) && vrf_cnt[I_RetireVRegIdx] == '0)
             || (I_RetireCCWEn && cc_cnt == '0));
  end

  always_ff @(posedge I_CLOCK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      for (int i = 0; i < NUM_RF; i++) rf_cnt[i] <= '0;
      for (int j = 0; j < NUM_VRF; j++) vrf_cnt[j] <= '0;
      cc_cnt        <= '0;
      O_Busy        <= 1'b0;
      O_StallCycles <= '0;
      O_Error       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RF; i++) rf_cnt[i] <= rf_nxt[i];
      for (int j = 0; j < NUM_VRF; j++) vrf_cnt[j] <= vrf_nxt[j];
      cc_cnt <= cc_nxt;
      O_Busy <= busy_nxt;
      if (I_LOCK && O_DepStallSignal && O_StallCycles != 16'hFFFF)
        O_StallCycles <= O_StallCycles + 16'd1;
      if (err_set) O_Error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: scalar vector table plus hand sequences
// for async reset, CC, VRF, flush and lock behaviour.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        lock;
  logic        issue;
  logic [3:0]  src1_idx, src2_idx, dest_idx, ret_idx;
  logic        src1_use, src2_use, dest_wr, ret_en;
  logic [5:0]  vsrc1_idx, vsrc2_idx, vdest_idx, vret_idx;
  logic        vsrc1_use, vsrc2_use, vdest_wr, vret_en;
  logic        cc_use, cc_wr, cc_ret, flush;
  logic        stall, issued, busy, err;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  reg_scoreboard dut (
    .I_CLOCK(clk), .I_RESETn(rst_n), .I_LOCK(lock), .I_Issue(issue),
    .I_Src1Idx(src1_idx), .I_Src1Use(src1_use),
    .I_Src2Idx(src2_idx), .I_Src2Use(src2_use),
    .I_VSrc1Idx(vsrc1_idx), .I_VSrc1Use(vsrc1_use),
    .I_VSrc2Idx(vsrc2_idx), .I_VSrc2Use(vsrc2_use),
    .I_CCUse(cc_use), .I_DestIdx(dest_idx), .I_DestWrite(dest_wr),
    .I_VDestIdx(vdest_idx), .I_VDestWrite(vdest_wr), .I_CCWrite(cc_wr),
    .I_RetireRegWEn(ret_en), .I_RetireRegIdx(ret_idx),
    .I_RetireVRegWEn(vret_en), .I_RetireVRegIdx(vret_idx),
    .I_RetireCCWEn(cc_ret), .I_Flush(flush),
    .O_DepStallSignal(stall), .O_Issued(issued), .O_Busy(busy),
    .O_StallCycles(stall_cycles), .O_Error(err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        issue;
    logic [3:0]  src1;
    logic        src1_use;
    logic [3:0]  dest;
    logic        dest_wr;
    logic        ret_en;
    logic [3:0]  ret_idx;
    logic        exp_stall;
    logic        exp_issued;
    logic        exp_busy;
    logic [15:0] exp_sc;
    logic        exp_err;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic i, input logic [3:0] s, input logic su,
                              input logic [3:0] d, input logic dw, input logic re,
                              input logic [3:0] ri, input logic es, input logic ei,
                              input logic eb, input logic [15:0] esc, input logic ee);
    vec_t v;
    v.issue = i; v.src1 = s; v.src1_use = su; v.dest = d; v.dest_wr = dw;
    v.ret_en = re; v.ret_idx = ri; v.exp_stall = es; v.exp_issued = ei;
    v.exp_busy = eb; v.exp_sc = esc; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    lock = 1'b1; issue = 1'b0; flush = 1'b0;
    src1_idx = '0; src1_use = 1'b0; src2_idx = '0; src2_use = 1'b0;
    vsrc1_idx = '0; vsrc1_use = 1'b0; vsrc2_idx = '0; vsrc2_use = 1'b0;
    cc_use = 1'b0; dest_idx = '0; dest_wr = 1'b0; vdest_idx = '0; vdest_wr = 1'b0;
    cc_wr = 1'b0; ret_en = 1'b0; ret_idx = '0; vret_en = 1'b0; vret_idx = '0;
    cc_ret = 1'b0;
  endtask

  // Inputs are already driven; check combinational outputs mid-cycle, then
  // registered busy just after the edge, then release the inputs.
  task automatic step(input string name, input logic e_stall, input logic e_issued,
                      input logic e_busy);
    @(negedge clk);
    chk1({name, ".stall"}, stall, e_stall);
    chk1({name, ".issued"}, issued, e_issued);
    @(posedge clk);
    #1;
    chk1({name, ".busy"}, busy, e_busy);
    clear_inputs();
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    tbl[0]  = mk(1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0);
    tbl[1]  = mk(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0);
    tbl[2]  = mk(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
    tbl[3]  = mk(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);
    tbl[4]  = mk(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
    tbl[5]  = mk(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
    tbl[6]  = mk(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
    tbl[7]  = mk(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0);
    tbl[8]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0);
    tbl[9]  = mk(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
    tbl[10] = mk(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 16'd4, 1'b0);
    tbl[11] = mk(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 16'd4, 1'b0);
    tbl[12] = mk(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
    tbl[13] = mk(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'd6, 1'b0);
    tbl[14] = mk(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd6, 1'b0);
    tbl[15] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 16'd6, 1'b1);
    tbl[16] = mk(1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'd6, 1'b1);

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset.busy", busy, 1'b0);
    chk16("reset.stall_cycles", stall_cycles, 16'd0);
    chk1("reset.error", err, 1'b0);
    chk1("reset.stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // scalar table
    for (int k = 0; k < 17; k++) begin
      issue = tbl[k].issue; src1_idx = tbl[k].src1; src1_use = tbl[k].src1_use;
      dest_idx = tbl[k].dest; dest_wr = tbl[k].dest_wr;
      ret_en = tbl[k].ret_en; ret_idx = tbl[k].ret_idx;
      @(negedge clk);
      chk1($sformatf("vec%0d.stall", k), stall, tbl[k].exp_stall);
      chk1($sformatf("vec%0d.issued", k), issued, tbl[k].exp_issued);
      @(posedge clk);
      #1;
      chk1($sformatf("vec%0d.busy", k), busy, tbl[k].exp_busy);
      chk16($sformatf("vec%0d.stall_cycles", k), stall_cycles, tbl[k].exp_sc);
      chk1($sformatf("vec%0d.error", k), err, tbl[k].exp_err);
      clear_inputs();
    end

    // asynchronous reset mid-cycle with R9 pending
    issue = 1'b1; src1_idx = 4'd9; src1_use = 1'b1;
    #1;
    chk1("pre_rst.stall", stall, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("async_rst.busy", busy, 1'b0);
    chk16("async_rst.stall_cycles", stall_cycles, 16'd0);
    chk1("async_rst.error", err, 1'b0);
    chk1("async_rst.stall", stall, 1'b0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // condition code
    issue = 1'b1; cc_wr = 1'b1;
    step("cc_wr", 1'b0, 1'b1, 1'b1);
    issue = 1'b1; cc_use = 1'b1;
    step("cc_use_wait", 1'b1, 1'b0, 1'b1);
    issue = 1'b1; cc_use = 1'b1; cc_ret = 1'b1;
    step("cc_use_retire", 1'b1, 1'b0, 1'b0);
    issue = 1'b1; cc_use = 1'b1;
    step("cc_use_go", 1'b0, 1'b1, 1'b0);

    // vector: simultaneous issue-write and retire on V10 keeps count at 1
    issue = 1'b1; vdest_idx = 6'd10; vdest_wr = 1'b1;
    step("v10_wr", 1'b0, 1'b1, 1'b1);
    issue = 1'b1; vdest_idx = 6'd10; vdest_wr = 1'b1; vret_en = 1'b1; vret_idx = 6'd10;
    step("v10_wr_ret", 1'b0, 1'b1, 1'b1);
    issue = 1'b1; vsrc1_idx = 6'd10; vsrc1_use = 1'b1;
    step("v10_use_wait", 1'b1, 1'b0, 1'b1);
    vret_en = 1'b1; vret_idx = 6'd10;
    step("v10_retire", 1'b0, 1'b0, 1'b0);
    issue = 1'b1; vsrc1_idx = 6'd10; vsrc1_use = 1'b1;
    step("v10_use_go", 1'b0, 1'b1, 1'b0);
    chk16("cc_vrf.stall_cycles", stall_cycles, 16'd3);

    // flush clears R1 and V2 and ignores the same-cycle issue
    issue = 1'b1; dest_idx = 4'd1; dest_wr = 1'b1;
    step("r1_wr", 1'b0, 1'b1, 1'b1);
    issue = 1'b1; vdest_idx = 6'd2; vdest_wr = 1'b1;
    step("v2_wr", 1'b0, 1'b1, 1'b1);
    issue = 1'b1; dest_idx = 4'd1; dest_wr = 1'b1; flush = 1'b1;
    step("flush", 1'b0, 1'b1, 1'b0);
    issue = 1'b1; src1_idx = 4'd1; src1_use = 1'b1; vsrc2_idx = 6'd2; vsrc2_use = 1'b1;
    step("post_flush_use", 1'b0, 1'b1, 1'b0);

    // lock low: stall still visible, nothing issues, no state moves
    issue = 1'b1; dest_idx = 4'd4; dest_wr = 1'b1;
    step("r4_wr", 1'b0, 1'b1, 1'b1);
    lock = 1'b0; issue = 1'b1; src1_idx = 4'd4; src1_use = 1'b1;
    step("lock0_stall", 1'b1, 1'b0, 1'b1);
    lock = 1'b0; issue = 1'b1; dest_idx = 4'd6; dest_wr = 1'b1; ret_en = 1'b1; ret_idx = 4'd4;
    step("lock0_hold", 1'b0, 1'b0, 1'b1);
    issue = 1'b1; src2_idx = 4'd4; src2_use = 1'b1;
    step("r4_src2_wait", 1'b1, 1'b0, 1'b1);
    ret_en = 1'b1; ret_idx = 4'd4;
    step("r4_retire", 1'b0, 1'b0, 1'b0);
    chk16("final.stall_cycles", stall_cycles, 16'd4);
    chk1("final.error", err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
